// File: rtl/gb_pkg.sv
// Shared constants, sizing helpers and read-tag pieces for the ghostbus router.
package gb_pkg;

  localparam int GB_CNT_W = 16;
  // Four select bits cover the local source plus up to 15 child channels.
  localparam int GB_SEL_W = 4;

  typedef logic [GB_SEL_W-1:0] gb_sel_t;

  function automatic int gb_win_w(input int aw, input int ch_aw);
    return aw - ch_aw;
  endfunction

  function automatic int gb_sel_w(input int nch);
    return $clog2(nch + 1);
  endfunction

  function automatic int gb_stat_off(input int nloc);
    return nloc;
  endfunction

endpackage

// File: rtl/gb_rd_pipe.sv
// Fixed-depth delay line for read tags; a synchronous clear drops everything in flight.
module gb_rd_pipe #(
  parameter int  DEPTH = 10,
  parameter type tag_t = logic
) (
  input  logic clk,
  input  logic clr,
  input  tag_t din,
  output tag_t dout
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/gb_router.sv
// Ghostbus router: decodes host accesses into child windows, local registers and a
// saturating unmapped-access counter, returning every read after exactly RD+2 cycles.
module gb_router
  import gb_pkg::*;
#(
  parameter int                 AW       = 24,
  parameter int                 DW       = 32,
  parameter int                 CH_AW    = 8,
  parameter int                 NCH      = 2,
  parameter int                 NLOC     = 4,
  parameter int                 RD       = 8,
  parameter logic [NLOC*DW-1:0] LOC_INIT = '0
) (
  input  logic                gb_clk,
  input  logic                gb_rst,
  input  logic [AW-1:0]       gb_addr,
  input  logic [DW-1:0]       gb_wdata,
  input  logic                gb_wen,
  input  logic                gb_rstb,
  output logic [DW-1:0]       gb_rdata,
  output logic                gb_rvalid,
  output logic [CH_AW-1:0]    ch_addr,
  output logic [DW-1:0]       ch_wdata,
  output logic [NCH-1:0]      ch_wen,
  output logic [NCH-1:0]      ch_rstb,
  input  logic [NCH*DW-1:0]   ch_rdata,
  output logic [NLOC*DW-1:0]  loc_regs
);

  localparam int WW       = gb_win_w(AW, CH_AW);
  localparam int LAT      = RD + 2;
  localparam int STAT_OFF = gb_stat_off(NLOC);

  if (WW < gb_sel_w(NCH)) begin : g_bad_win
    $error("gb_router: AW-CH_AW too narrow to index NCH child windows");
  end
  if (NCH < 1 || NCH > 15) begin : g_bad_nch
    $error("gb_router: NCH must be in 1..15");
  end

  typedef struct packed {
    logic          valid;
    gb_sel_t       sel;
    logic [DW-1:0] snap;
  } rd_tag_t;

  logic [WW-1:0]    win;
  logic [CH_AW-1:0] off;
  logic             is_loc, is_stat, is_ch, unmapped;

  logic [DW-1:0]       loc_q [NLOC];
  logic [DW-1:0]       loc_d [NLOC];
  logic [GB_CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]      ch_wen_q, ch_wen_d;
  logic [NCH-1:0]      ch_rstb_q, ch_rstb_d;
  logic [CH_AW-1:0]    ch_addr_q, ch_addr_d;
  logic [DW-1:0]       ch_wdata_q, ch_wdata_d;
  logic [NCH*DW-1:0]   ch_rdata_q;
  logic [DW-1:0]       snap_loc;
  rd_tag_t             tag_in, tag_out;

  assign win      = gb_addr[AW-1:CH_AW];
  assign off      = gb_addr[CH_AW-1:0];
  assign is_loc   = (win == '0) && (off < CH_AW'(NLOC));
  assign is_stat  = (win == '0) && (off == CH_AW'(STAT_OFF));
  assign is_ch    = (win != '0) && (win <= WW'(NCH));
  assign unmapped = !(is_loc || is_stat || is_ch);

  always_comb begin
    loc_d    = loc_q;
    snap_loc = '0;
    for (int i = 0; i < NLOC; i++) begin
      if (off == CH_AW'(i)) begin
        snap_loc = loc_q[i];
        if (gb_wen && is_loc) loc_d[i] = gb_wdata;
      end
    end

    // A combined write+read to one unmapped address counts as a single access.
    cnt_d = cnt_q;
    if ((gb_wen || gb_rstb) && unmapped && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    ch_wen_d  = '0;
    ch_rstb_d = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_wen_d[k]  = gb_wen  && is_ch && (win == WW'(k + 1));
      ch_rstb_d[k] = gb_rstb && is_ch && (win == WW'(k + 1));
    end

    ch_addr_d  = ch_addr_q;
    ch_wdata_d = ch_wdata_q;
    if ((gb_wen || gb_rstb) && is_ch) ch_addr_d = off;
    if (gb_wen && is_ch) ch_wdata_d = gb_wdata;

    tag_in.valid = gb_rstb;
    tag_in.sel   = is_ch ? GB_SEL_W'(win) : '0;
    if (is_loc)       tag_in.snap = snap_loc;
    else if (is_stat) tag_in.snap = DW'(cnt_q);
    else              tag_in.snap = '0;
  end

  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      for (int i = 0; i < NLOC; i++) loc_q[i] <= LOC_INIT[i*DW +: DW];
      cnt_q      <= '0;
      ch_wen_q   <= '0;
      ch_rstb_q  <= '0;
      ch_addr_q  <= '0;
      ch_wdata_q <= '0;
      ch_rdata_q <= '0;
    end else begin
      loc_q      <= loc_d;
      cnt_q      <= cnt_d;
      ch_wen_q   <= ch_wen_d;
      ch_rstb_q  <= ch_rstb_d;
      ch_addr_q  <= ch_addr_d;
      ch_wdata_q <= ch_wdata_d;
      ch_rdata_q <= ch_rdata;
    end
  end

  gb_rd_pipe #(
    .DEPTH (LAT),
    .tag_t (rd_tag_t)
  ) u_rd_pipe (
    .clk  (gb_clk),
    .clr  (gb_rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  // Child data captured in the cycle before the tag leaves the pipe lines up with it here.
  always_comb begin
    gb_rdata = '0;
    if (tag_out.valid) begin
      if (tag_out.sel == '0) gb_rdata = tag_out.snap;
      for (int k = 0; k < NCH; k++) begin
        if (tag_out.sel == GB_SEL_W'(k + 1)) gb_rdata = ch_rdata_q[k*DW +: DW];
      end
    end
  end

  always_comb begin
    loc_regs = '0;
    for (int i = 0; i < NLOC; i++) loc_regs[i*DW +: DW] = loc_q[i];
  end

  assign gb_rvalid = tag_out.valid;
  assign ch_wen    = ch_wen_q;
  assign ch_rstb   = ch_rstb_q;
  assign ch_addr   = ch_addr_q;
  assign ch_wdata  = ch_wdata_q;

endmodule

// File: tb/tb_gb_router.sv
// Scoreboard bench for gb_router: reads push expected data/arrival cycle, a negedge
// monitor pops and compares; children are modelled as fixed-latency responders.
module tb_gb_router;

  localparam int AW = 24, DW = 32, CH_AW = 8, NCH = 2, NLOC = 4, RD = 8;
  localparam int LAT = RD + 2;
  localparam logic [NLOC*DW-1:0] LOC_INIT = 128'h42;

  logic              gb_clk = 1'b0;
  logic              gb_rst;
  logic [AW-1:0]     gb_addr;
  logic [DW-1:0]     gb_wdata;
  logic              gb_wen, gb_rstb;
  logic [DW-1:0]     gb_rdata;
  logic              gb_rvalid;
  logic [CH_AW-1:0]  ch_addr;
  logic [DW-1:0]     ch_wdata;
  logic [NCH-1:0]    ch_wen, ch_rstb;
  logic [NCH*DW-1:0] ch_rdata;
  logic [NLOC*DW-1:0] loc_regs;

  gb_router #(
    .AW(AW), .DW(DW), .CH_AW(CH_AW), .NCH(NCH), .NLOC(NLOC), .RD(RD), .LOC_INIT(LOC_INIT)
  ) dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
    .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(gb_rdata), .gb_rvalid(gb_rvalid),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wen(ch_wen), .ch_rstb(ch_rstb),
    .ch_rdata(ch_rdata), .loc_regs(loc_regs)
  );

  always #5 gb_clk = ~gb_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge gb_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Child model: channel k answers a strobe seen in cycle c with data in cycle c+RD.
  typedef struct packed {
    logic [NCH-1:0]   v;
    logic [CH_AW-1:0] a;
  } smp_t;
  smp_t sr [RD];

  function automatic logic [31:0] chval(input int k, input logic [7:0] a);
    logic [15:0] hi;
    hi = 16'h1111 * 16'(k + 1);
    return {hi, 8'h00, a};
  endfunction

  always @(posedge gb_clk) begin
    sr[0] <= '{v: ch_rstb, a: ch_addr};
    for (int i = 1; i < RD; i++) sr[i] <= sr[i-1];
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch_rdata[k*DW +: DW] = sr[RD-1].v[k] ? chval(k, sr[RD-1].a) : (32'hBAD0_0000 | 32'(k));
    end
  end

  // Scoreboard
  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge gb_clk) begin
    if (gb_rvalid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_rvalid", 32'(gb_rvalid), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rd_latency", 32'(cyc), 32'(e.due));
        chk("rd_data", gb_rdata, e.d);
      end
    end else begin
      chk("rdata_idle", gb_rdata, 32'h0);
    end
  end

  // Reference state
  logic [31:0] mloc [NLOC];
  int          mcnt;

  task automatic model_reset();
    for (int i = 0; i < NLOC; i++) mloc[i] = LOC_INIT[i*DW +: DW];
    mcnt = 0;
  endtask

  task automatic model_unmapped();
    if (mcnt < 32'hFFFF) mcnt++;
  endtask

  task automatic step();
    @(posedge gb_clk);
    #1;
  endtask

  task automatic rd(input logic [23:0] a, input logic [31:0] exp);
    gb_addr = a;
    gb_rstb = 1'b1;
    sb_q.push_back('{d: exp, due: cyc + LAT});
    step();
    gb_rstb = 1'b0;
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d);
    gb_addr  = a;
    gb_wdata = d;
    gb_wen   = 1'b1;
    step();
    gb_wen = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 3) step();
  endtask

  initial begin
    gb_rst = 1'b1; gb_addr = '0; gb_wdata = '0; gb_wen = 1'b0; gb_rstb = 1'b0;
    model_reset();
    step(); step();
    gb_rst = 1'b0;
    @(negedge gb_clk);
    chk("rst_rvalid", 32'(gb_rvalid), 32'h0);
    chk("rst_ch_wen", 32'(ch_wen), 32'h0);
    chk("rst_ch_rstb", 32'(ch_rstb), 32'h0);
    chk("rst_ch_addr", 32'(ch_addr), 32'h0);
    chk("rst_ch_wdata", ch_wdata, 32'h0);
    chk("rst_loc0", loc_regs[31:0], 32'h42);
    chk("rst_loc1", loc_regs[63:32], 32'h0);
    step();

    // Local read of reset value
    rd(24'h000000, mloc[0]);
    drain();

    // Child write and child read
    wr(24'h000203, 32'hCAFEF00D);
    @(negedge gb_clk);
    chk("wr_ch_wen", 32'(ch_wen), 32'h2);
    chk("wr_ch_addr", 32'(ch_addr), 32'h03);
    chk("wr_ch_wdata", ch_wdata, 32'hCAFEF00D);
    step();
    @(negedge gb_clk);
    chk("wr_ch_wen_1cyc", 32'(ch_wen), 32'h0);
    step();
    rd(24'h000105, 32'h11110005);
    @(negedge gb_clk);
    chk("rd_ch_rstb", 32'(ch_rstb), 32'h1);
    chk("rd_ch_addr", 32'(ch_addr), 32'h05);
    drain();

    // Ten back-to-back mixed reads
    for (int i = 0; i < 10; i++) begin
      case (i % 4)
        0: rd(24'h000001, mloc[1]);
        1: rd(24'h000100, chval(0, 8'h00));
        2: rd(24'h000200, chval(1, 8'h00));
        default: begin rd(24'h000300, 32'h0); model_unmapped(); end
      endcase
    end
    rd(24'h000004, 32'(mcnt));
    drain();

    // Same-cycle write and read to a local register
    gb_addr = 24'h000002; gb_wdata = 32'h5; gb_wen = 1'b1; gb_rstb = 1'b1;
    sb_q.push_back('{d: mloc[2], due: cyc + LAT});
    step();
    gb_wen = 1'b0; gb_rstb = 1'b0;
    mloc[2] = 32'h5;
    @(negedge gb_clk);
    chk("loc2_after_wr", loc_regs[95:64], mloc[2]);
    step();

    // Status is read-only; window-0 hole and combined unmapped access count once each
    wr(24'h000004, 32'h1234);
    wr(24'h000005, 32'h9999);
    model_unmapped();
    gb_addr = 24'h000300; gb_wen = 1'b1; gb_rstb = 1'b1;
    sb_q.push_back('{d: 32'h0, due: cyc + LAT});
    step();
    gb_wen = 1'b0; gb_rstb = 1'b0;
    model_unmapped();
    rd(24'h000004, 32'(mcnt));
    drain();

    // Saturate the counter, then three more unmapped writes
    begin
      int n;
      n = 32'hFFFF - mcnt + 3;
      gb_addr = 24'h000300; gb_wen = 1'b1;
      for (int i = 0; i < n; i++) begin
        model_unmapped();
        step();
      end
      gb_wen = 1'b0;
    end
    rd(24'h000004, 32'(mcnt));
    drain();

    // Reset with four child reads in flight
    for (int i = 0; i < 4; i++) begin
      gb_addr = 24'h000100 + 24'(i);
      gb_rstb = 1'b1;
      if (i == 3) gb_rst = 1'b1;
      step();
    end
    gb_rstb = 1'b0; gb_rst = 1'b0;
    model_reset();
    @(negedge gb_clk);
    chk("rst_mid_ch_rstb", 32'(ch_rstb), 32'h0);
    chk("rst_mid_loc2", loc_regs[95:64], mloc[2]);
    step();
    rd(24'h000000, mloc[0]);
    rd(24'h000004, 32'(mcnt));
    drain();

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
